mem_sram_slave: RTL and testbench

- Memory-side slave behind the AXI-lite-to-Mem bridge. It consumes the level-held ren/raddr and wen/waddr/wdata/wmask requests and answers with rvalid/rdata and wvalid.
- On-chip byte-maskable SRAM with programmable read and write latency. Used as the simulation and FPGA backing store for the core's data path.
- Serves one request at a time. Tolerates the requester keeping its enable high for one cycle after completion.

---
 rtl/mem_sram_pkg.sv | 54 +++++
 rtl/mem_sram_array.sv | 38 +++
 rtl/mem_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_mem_sram_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_pkg.sv
// Shared types and address helpers for the memory-side SRAM slave.
package mem_sram_pkg;

  // Request/response sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    RBUSY,
    WBUSY,
    RDONE,
    WDONE
  } state_e;

  // Geometry of the default configuration. Instances with other parameters
  // derive their own values through the helper functions below.
  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned DEPTH_DEF      = 4096;
  localparam int unsigned BYTES          = DATA_WIDTH_DEF / 8;
  localparam int unsigned OFFSET_BITS    = $clog2(BYTES);
  localparam int unsigned IDX_W          = $clog2(DEPTH_DEF);

  // Address arithmetic is done at 64 bits; narrower address buses are
  // zero-extended by the caller, so ADDR_WIDTH must not exceed 64.
  localparam int unsigned MAX_ADDR_W = 64;

  // Number of byte lanes in a data word.
  function automatic int unsigned bytes_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Larger of the two latencies; sizes the shared countdown register.
  function automatic int unsigned max_latency(input int unsigned rd_lat,
                                              input int unsigned wr_lat);
    return (rd_lat > wr_lat) ? rd_lat : wr_lat;
  endfunction

  // Word index of a byte address relative to the array base. Low address
  // bits inside a word are discarded, so accesses are always word aligned.
  function automatic logic [MAX_ADDR_W-1:0] word_index(
      input logic [MAX_ADDR_W-1:0] addr,
      input logic [MAX_ADDR_W-1:0] base,
      input int unsigned           offset_bits);
    return (addr - base) >> offset_bits;
  endfunction

  // True when the byte address falls inside the DEPTH-word window at base.
  function automatic logic in_range(
      input logic [MAX_ADDR_W-1:0] addr,
      input logic [MAX_ADDR_W-1:0] base,
      input logic [MAX_ADDR_W-1:0] depth,
      input int unsigned           offset_bits);
    return (addr >= base) && (word_index(addr, base, offset_bits) < depth);
  endfunction

endpackage : mem_sram_pkg

// File: rtl/mem_sram_array.sv
// DEPTH x DATA_WIDTH storage: combinational read port, byte-masked write port.
module mem_sram_array
  import mem_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned IDX_BITS   = 12
) (
  input  logic                    clk,
  input  logic [IDX_BITS-1:0]     rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    we_i,
  input  logic [IDX_BITS-1:0]     wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_mask_i
);

  localparam int unsigned NUM_BYTES = bytes_of(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[rd_idx_i];

  // Byte-lane write: only lanes whose mask bit is set are updated.
  // NOTE: the storage has no reset branch; clearing a RAM would need a
  // per-word loop that prevents mapping onto block RAM, and the contents
  // are defined only once written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_mask_i[b]) begin
          mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

endmodule : mem_sram_array

// File: rtl/mem_sram_slave.sv
// Memory-side slave: level-held read/write requests, programmable latency,
// byte-maskable on-chip SRAM. One request is serviced at a time.
module mem_sram_slave
  import mem_sram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_LATENCY = 2,
  parameter int unsigned           WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  output logic                    wvalid
);

  localparam int unsigned NUM_BYTES = bytes_of(DATA_WIDTH);
  localparam int unsigned OFF_BITS  = $clog2(NUM_BYTES);
  localparam int unsigned IDX_BITS  = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(max_latency(RD_LATENCY, WR_LATENCY) + 1);

  localparam logic [MAX_ADDR_W-1:0] BASE64  = MAX_ADDR_W'(BASE_ADDR);
  localparam logic [MAX_ADDR_W-1:0] DEPTH64 = MAX_ADDR_W'(DEPTH);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    rvalid_q;
  logic                    wvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_BYTES-1:0]    wmask_q;

  logic                    rd_in_range;
  logic                    wr_in_range;
  logic [IDX_BITS-1:0]     rd_idx;
  logic [IDX_BITS-1:0]     wr_idx;
  logic [DATA_WIDTH-1:0]   array_rdata;
  logic [DATA_WIDTH-1:0]   rd_word_d;
  logic                    mem_we_d;

  // Decode works from the captured request, never from the live inputs,
  // so the requester may change address/data while the access is in flight.
  assign rd_in_range = in_range(MAX_ADDR_W'(raddr_q), BASE64, DEPTH64, OFF_BITS);
  assign wr_in_range = in_range(MAX_ADDR_W'(waddr_q), BASE64, DEPTH64, OFF_BITS);
  assign rd_idx      = IDX_BITS'(word_index(MAX_ADDR_W'(raddr_q), BASE64, OFF_BITS));
  assign wr_idx      = IDX_BITS'(word_index(MAX_ADDR_W'(waddr_q), BASE64, OFF_BITS));

  // Commit happens on the edge that moves WBUSY to WDONE. Reset and an
  // aborting requester both suppress it, and out-of-range writes never
  // reach the array even though they still complete.
  assign mem_we_d = !rst && (state_q == WBUSY) && wen && (cnt_q == '0) && wr_in_range;

  // Read word returned on completion: array contents in range, zero outside.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    rd_word_d = '0;
    if (rd_in_range) begin
      rd_word_d = array_rdata;
    end
  end

  mem_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_BITS   (IDX_BITS)
  ) u_array (
    .clk       (clk),
    .rd_idx_i  (rd_idx),
    .rd_data_o (array_rdata),
    .we_i      (mem_we_d),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wdata_q),
    .wr_mask_i (wmask_q)
  );

  // Request sequencer: accept, count down the latency, complete, then wait
  // for the requester to drop its enable before looking at new requests.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values and ordering within the block is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      rdata_q  <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Write wins when both enables are high.
          if (wen) begin
            waddr_q <= waddr;
            wdata_q <= wdata;
            wmask_q <= wmask;
            cnt_q   <= CNT_W'(WR_LATENCY - 1);
            state_q <= WBUSY;
          end else if (ren) begin
            raddr_q <= raddr;
            cnt_q   <= CNT_W'(RD_LATENCY - 1);
            state_q <= RBUSY;
          end
        end

        RBUSY: begin
          if (!ren) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            rdata_q  <= rd_word_d;
            rvalid_q <= 1'b1;
            state_q  <= RDONE;
          end
        end

        WBUSY: begin
          if (!wen) begin
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            wvalid_q <= 1'b1;
            state_q  <= WDONE;
          end
        end

        RDONE: begin
          // rdata_q is left alone: it holds until the next read completes.
          if (!ren) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        WDONE: begin
          if (!wen) begin
            wvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: begin
          rvalid_q <= 1'b0;
          wvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wvalid = wvalid_q;

endmodule : mem_sram_slave

// File: tb/tb_mem_sram_slave.sv
// Self-checking bench for mem_sram_slave. Three instances with different
// base address and latencies share clk/rst; a byte-level reference model
// keyed by instance and word predicts every read.
module tb_mem_sram_slave;

  localparam int NI    = 3;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int DEPTH = 4096;

  function automatic int rd_lat(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int wr_lat(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  function automatic logic [63:0] base_of(input int k);
    return (k == 1) ? 64'h1000 : 64'h0;
  endfunction

  logic          clk;
  logic          rst;
  logic          ren    [NI];
  logic [AW-1:0] raddr  [NI];
  logic [DW-1:0] rdata  [NI];
  logic          rvalid [NI];
  logic          wen    [NI];
  logic [AW-1:0] waddr  [NI];
  logic [DW-1:0] wdata  [NI];
  logic [7:0]    wmask  [NI];
  logic          wvalid [NI];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_sram_slave #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .BASE_ADDR  (base_of(g)),
      .RD_LATENCY (rd_lat(g)),
      .WR_LATENCY (wr_lat(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .ren    (ren[g]),
      .raddr  (raddr[g]),
      .rdata  (rdata[g]),
      .rvalid (rvalid[g]),
      .wen    (wen[g]),
      .waddr  (waddr[g]),
      .wdata  (wdata[g]),
      .wmask  (wmask[g]),
      .wvalid (wvalid[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [63:0] model [int];

  function automatic bit model_in_range(input int k, input logic [63:0] a);
    return (a >= base_of(k)) && (((a - base_of(k)) / 8) < 64'(DEPTH));
  endfunction

  function automatic int model_key(input int k, input logic [63:0] a);
    return k * DEPTH + int'((a - base_of(k)) / 8);
  endfunction

  task automatic model_write(input int k, input logic [63:0] a,
                             input logic [63:0] d, input logic [7:0] m);
    logic [63:0] w;
    if (model_in_range(k, a)) begin
      w = model.exists(model_key(k, a)) ? model[model_key(k, a)] : 64'hx;
      for (int b = 0; b < 8; b++) begin
        if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
      end
      model[model_key(k, a)] = w;
    end
  endtask

  function automatic logic [63:0] model_read(input int k, input logic [63:0] a);
    if (!model_in_range(k, a)) return 64'h0;
    return model[model_key(k, a)];
  endfunction

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exclusivity of the two completion flags, checked on every falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (rvalid[k] === 1'b1 && wvalid[k] === 1'b1) begin
          errors++;
          $display("FAIL excl inst%0d: rvalid and wvalid both high at %0t", k, $time);
        end
      end
    end
  end

  // Full write handshake: latency, bridge-style hold, release. Inputs are
  // scrambled after acceptance to prove the captured values are used.
  task automatic do_write(input int k, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] m, input string tag);
    int n;
    waddr[k] = a; wdata[k] = d; wmask[k] = m; wen[k] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        waddr[k] = {$urandom, $urandom};
        wdata[k] = {$urandom, $urandom};
        wmask[k] = 8'($urandom);
      end
    end while (wvalid[k] !== 1'b1 && n < 40);
    checks++;
    if (n != wr_lat(k) + 1) begin
      errors++;
      $display("FAIL %s wr_latency inst%0d: got %0d edges, expected %0d", tag, k, n - 1, wr_lat(k));
    end
    tick();
    checks++;
    if (wvalid[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s wr_hold inst%0d: wvalid=%b, expected 1", tag, k, wvalid[k]);
    end
    wen[k] = 1'b0;
    tick();
    checks++;
    if (wvalid[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s wr_release inst%0d: wvalid=%b, expected 0", tag, k, wvalid[k]);
    end
    model_write(k, a, d, m);
  endtask

  // Full read handshake with latency, data, hold and retention checks.
  task automatic do_read(input int k, input logic [63:0] a, input logic [63:0] exp,
                         input string tag);
    int n;
    raddr[k] = a; ren[k] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) raddr[k] = {$urandom, $urandom};
    end while (rvalid[k] !== 1'b1 && n < 40);
    checks++;
    if (n != rd_lat(k) + 1) begin
      errors++;
      $display("FAIL %s rd_latency inst%0d: got %0d edges, expected %0d", tag, k, n - 1, rd_lat(k));
    end
    checks++;
    if (rdata[k] !== exp) begin
      errors++;
      $display("FAIL %s rd_data inst%0d addr=%h: got %h, expected %h", tag, k, a, rdata[k], exp);
    end
    tick();
    checks++;
    if (rvalid[k] !== 1'b1 || rdata[k] !== exp) begin
      errors++;
      $display("FAIL %s rd_hold inst%0d: rvalid=%b rdata=%h, expected 1/%h", tag, k, rvalid[k], rdata[k], exp);
    end
    ren[k] = 1'b0;
    tick();
    checks++;
    if (rvalid[k] !== 1'b0 || rdata[k] !== exp) begin
      errors++;
      $display("FAIL %s rd_release inst%0d: rvalid=%b rdata=%h, expected 0/%h", tag, k, rvalid[k], rdata[k], exp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (rvalid[k] !== 1'b0 || wvalid[k] !== 1'b0 || rdata[k] !== 64'h0) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d: rvalid=%b wvalid=%b rdata=%h, expected 0/0/0",
                   k, c, rvalid[k], wvalid[k], rdata[k]);
        end
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_masked_write_read();
    do_write(0, 64'h40, 64'h1122334455667788, 8'hFF, "mask_full");
    do_write(0, 64'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F, "mask_low");
    do_read(0, 64'h40, 64'h11223344AAAAAAAA, "mask_read");
    // Back-to-back read on the earliest allowed cycle, unaligned address.
    do_read(0, 64'h45, 64'h11223344AAAAAAAA, "b2b_read");
  endtask

  task automatic test_simultaneous();
    int n;
    logic [63:0] d;
    d = {$urandom, $urandom};
    waddr[0] = 64'h80; wdata[0] = d; wmask[0] = 8'hFF; wen[0] = 1'b1;
    raddr[0] = 64'h40; ren[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (wvalid[0] !== 1'b1 && n < 40);
    checks++;
    if (n != wr_lat(0) + 1 || rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL simul write_first: edges=%0d rvalid=%b, expected %0d/0", n - 1, rvalid[0], wr_lat(0));
    end
    model_write(0, 64'h80, d, 8'hFF);
    tick();
    checks++;
    if (wvalid[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL simul hold: wvalid=%b rvalid=%b, expected 1/0", wvalid[0], rvalid[0]);
    end
    wen[0] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (rvalid[0] !== 1'b1 && n < 40);
    // One edge to leave WDONE, one to accept, then the read latency.
    checks++;
    if (n != rd_lat(0) + 2) begin
      errors++;
      $display("FAIL simul read_after: got %0d edges after wen drop, expected %0d", n, rd_lat(0) + 2);
    end
    checks++;
    if (rdata[0] !== model_read(0, 64'h40)) begin
      errors++;
      $display("FAIL simul rdata: got %h, expected %h", rdata[0], model_read(0, 64'h40));
    end
    ren[0] = 1'b0;
    tick();
    checks++;
    if (rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL simul release: rvalid=%b, expected 0", rvalid[0]);
    end
    do_read(0, 64'h80, model_read(0, 64'h80), "simul_readback");
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    d = {$urandom, $urandom};
    do_write(1, 64'h1000, d, 8'hFF, "oor_init");
    do_read(1, 64'h0, 64'h0, "oor_read_low");
    do_read(1, 64'h1000 + 64'(DEPTH) * 8 + 64'h10, 64'h0, "oor_read_high");
    do_write(1, 64'h1000 + 64'(DEPTH) * 8, ~d, 8'hFF, "oor_write");
    do_read(1, 64'h1000, d, "oor_word0");
  endtask

  task automatic test_abort();
    logic [63:0] keep;
    logic [63:0] d0;
    do_read(0, 64'h40, model_read(0, 64'h40), "abort_pre");
    keep = model_read(0, 64'h40);
    raddr[0] = 64'h80; ren[0] = 1'b1;
    tick();
    ren[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (rvalid[0] !== 1'b0 || rdata[0] !== keep) begin
        errors++;
        $display("FAIL abort_read cyc%0d: rvalid=%b rdata=%h, expected 0/%h", c, rvalid[0], rdata[0], keep);
      end
    end
    // Write abort on the long-latency instance: no commit may happen.
    d0 = {$urandom, $urandom};
    do_write(2, 64'h200, d0, 8'hFF, "abort_wr_init");
    waddr[2] = 64'h200; wdata[2] = ~d0; wmask[2] = 8'hFF; wen[2] = 1'b1;
    tick();
    tick();
    wen[2] = 1'b0;
    tick();
    checks++;
    if (wvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_write wvalid: got %b, expected 0", wvalid[2]);
    end
    do_read(2, 64'h200, d0, "abort_wr_readback");
  endtask

  task automatic test_random(input int k);
    logic [63:0] words [8];
    logic [63:0] a;
    logic [63:0] d;
    for (int i = 0; i < 8; i++) begin
      words[i] = base_of(k) + 64'(8 * $urandom_range(0, DEPTH - 1));
      do_write(k, words[i] + 64'($urandom_range(0, 7)), {$urandom, $urandom}, 8'hFF, "rand_init");
    end
    for (int op = 0; op < 30; op++) begin
      a = words[$urandom_range(0, 7)] + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom};
        do_write(k, a, d, 8'($urandom), "rand_write");
      end else begin
        do_read(k, a, model_read(k, a), "rand_read");
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] d0;
    d0 = {$urandom, $urandom};
    do_write(2, 64'h100, d0, 8'hFF, "rstw_init");
    waddr[2] = 64'h100; wdata[2] = ~d0; wmask[2] = 8'hFF; wen[2] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    wen[2] = 1'b0;
    tick();
    checks++;
    if (wvalid[2] !== 1'b0 || rvalid[2] !== 1'b0 || rdata[2] !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_write outputs: wvalid=%b rvalid=%b rdata=%h, expected 0/0/0",
               wvalid[2], rvalid[2], rdata[2]);
    end
    rst = 1'b0;
    tick();
    do_read(2, 64'h100, d0, "rstw_readback");
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      ren[k] = 1'b0; raddr[k] = '0; wen[k] = 1'b0;
      waddr[k] = '0; wdata[k] = '0; wmask[k] = '0;
    end
    test_reset();
    test_masked_write_read();
    test_simultaneous();
    test_out_of_range();
    test_abort();
    test_random(0);
    test_random(2);
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario stalls despite its own bounds.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mem_sram_slave
